// File: rtl/bcd_button_counter.sv
// Four-digit BCD up/down counter driven by three debounced push buttons.
// Feeds digit values, a leading-zero enable mask and the decimal flag to the display decoder.
module bcd_button_counter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clear,
    input  logic [1:0] step,
    input  logic       blank_leading,
    output logic [3:0] v3,
    output logic [3:0] v2,
    output logic [3:0] v1,
    output logic [3:0] v0,
    output logic [3:0] digits,
    output logic       decimal,
    output logic       wrap
);

    localparam logic [19:0] CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    // Button lanes: bit 0 = up, bit 1 = down, bit 2 = clear.
    logic [2:0]  raw;
    logic [2:0]  sync1;
    logic [2:0]  sync2;
    logic [2:0]  stable;
    logic [2:0]  stable_q;
    logic [2:0]  press;
    logic [19:0] cnt [3];

    logic [3:0]  val      [4];
    logic [3:0]  val_next [4];
    logic [3:0]  inc_val  [4];
    logic [3:0]  dec_val  [4];
    logic        inc_carry;
    logic        dec_borrow;
    logic        wrap_next;

    assign raw = {btn_clear, btn_down, btn_up};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            press    <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            press    <= stable & ~stable_q;
            // Any cycle where the synchronized level agrees with stable restarts the count.
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 20'd1;
                end
            end
        end
    end

    // Digit-serial ripple starting at the selected digit; lower digits pass through.
    always_comb begin
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inc_val[i] = val[i];
            dec_val[i] = val[i];
            if (i >= int'(step)) begin
                if (inc_carry) begin
                    if (val[i] == 4'd9) begin
                        inc_val[i] = 4'd0;
                    end else begin
                        inc_val[i] = val[i] + 4'd1;
                        inc_carry  = 1'b0;
                    end
                end
                if (dec_borrow) begin
                    if (val[i] == 4'd0) begin
                        dec_val[i] = 4'd9;
                    end else begin
                        dec_val[i] = val[i] - 4'd1;
                        dec_borrow = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        val_next  = val;
        wrap_next = 1'b0;
        if (press[2]) begin
            val_next = '{default: 4'd0};
        end else if (press[0] && press[1]) begin
            val_next = val;
        end else if (press[0]) begin
            val_next  = inc_val;
            wrap_next = inc_carry;
        end else if (press[1]) begin
            val_next  = dec_val;
            wrap_next = dec_borrow;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            val  <= '{default: 4'd0};
            wrap <= 1'b0;
        end else begin
            val  <= val_next;
            wrap <= wrap_next;
        end
    end

    assign v0 = val[0];
    assign v1 = val[1];
    assign v2 = val[2];
    assign v3 = val[3];

    // A digit is lit when it or any more significant digit is nonzero; units always lit.
    always_comb begin
        digits = 4'b1111;
        if (blank_leading) begin
            digits[3] = (val[3] != 4'd0);
            digits[2] = (val[3] != 4'd0) || (val[2] != 4'd0);
            digits[1] = (val[3] != 4'd0) || (val[2] != 4'd0) || (val[1] != 4'd0);
            digits[0] = 1'b1;
        end
    end

    assign decimal = 1'b1;

endmodule

// File: tb/tb_bcd_button_counter.sv
// Randomized and directed bench for bcd_button_counter against a window-based
// reference model; expected updates flow through a queue to an independent monitor.
module tb_bcd_button_counter;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       btn_clear;
    logic [1:0] step;
    logic       blank_leading;
    logic [3:0] v3, v2, v1, v0;
    logic [3:0] digits;
    logic       decimal;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    bcd_button_counter #(.DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_clear     (btn_clear),
        .step          (step),
        .blank_leading (blank_leading),
        .v3            (v3),
        .v2            (v2),
        .v1            (v1),
        .v0            (v0),
        .digits        (digits),
        .decimal       (decimal),
        .wrap          (wrap)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp_v, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // exp_q entry: [48:17] update cycle, [16:1] BCD value, [0] wrap
    logic [48:0] exp_q[$];
    logic [34:0] pend_q[$];
    bit          hist[3][$];
    bit          acc[3];
    int          cyc = 0;
    int          mval = 0;
    bit          model_ready = 0;

    function automatic logic [15:0] to_bcd(input int val);
        return {4'(val / 1000), 4'((val / 100) % 10), 4'((val / 10) % 10), 4'(val % 10)};
    endfunction

    function automatic logic [3:0] exp_digits(input int val, input logic bl);
        logic [3:0] d;
        if (!bl) return 4'b1111;
        d = 4'b0001;
        if (val >= 10)   d[1] = 1'b1;
        if (val >= 100)  d[2] = 1'b1;
        if (val >= 1000) d[3] = 1'b1;
        return d;
    endfunction

    task automatic apply_event(input logic [2:0] ev);
        int old_val;
        int inc;
        int s;
        bit wr;
        old_val = mval;
        wr      = 1'b0;
        case (step)
            2'd0: inc = 1;
            2'd1: inc = 10;
            2'd2: inc = 100;
            default: inc = 1000;
        endcase
        if (ev[2]) begin
            mval = 0;
        end else if (ev[1] && ev[0]) begin
            mval = old_val;
        end else if (ev[0]) begin
            s    = mval + inc;
            wr   = (s >= 10000);
            mval = s % 10000;
        end else if (ev[1]) begin
            s    = mval - inc;
            wr   = (s < 0);
            mval = wr ? s + 10000 : s;
        end
        if (mval != old_val || wr)
            exp_q.push_back({32'(cyc), to_bcd(mval), wr});
    endtask

    // A level is accepted once D consecutive raw samples differ from the accepted level;
    // the counter reflects an accepted press four edges after its last sample.
    always @(posedge clk) begin
        logic [2:0]  raw_s;
        logic [2:0]  pressed;
        logic [34:0] ev;
        bit          all_diff;
        cyc++;
        if (rst) begin
            mval = 0;
            for (int b = 0; b < 3; b++) begin
                acc[b] = 1'b0;
                hist[b].delete();
            end
            pend_q.delete();
            model_ready = 1'b1;
        end else begin
            if (pend_q.size() > 0 && pend_q[0][34:3] == 32'(cyc)) begin
                ev = pend_q.pop_front();
                apply_event(ev[2:0]);
            end
            raw_s   = {btn_clear, btn_down, btn_up};
            pressed = 3'b000;
            for (int b = 0; b < 3; b++) begin
                hist[b].push_back(raw_s[b]);
                if (hist[b].size() > D) void'(hist[b].pop_front());
                if (hist[b].size() == D) begin
                    all_diff = 1'b1;
                    foreach (hist[b][k]) if (hist[b][k] == acc[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        acc[b] = ~acc[b];
                        if (acc[b]) pressed[b] = 1'b1;
                    end
                end
            end
            if (pressed != 3'b000) pend_q.push_back({32'(cyc + 4), pressed});
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [15:0] prev_obs;
    always @(posedge clk) begin
        logic [15:0] obs;
        logic [48:0] e;
        #1;
        if (model_ready) begin
            obs = {v3, v2, v1, v0};
            if (!rst) begin
                if (obs != prev_obs || wrap) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_update actual=%h wrap=%b expected=no change at cycle %0d", obs, wrap, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("upd_value", 32'(obs), 32'(e[16:1]));
                        check("upd_wrap", 32'(wrap), 32'(e[0]));
                        check("upd_cycle", 32'(cyc), e[48:17]);
                    end
                end else if (exp_q.size() > 0 && exp_q[0][48:17] <= 32'(cyc)) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_update actual=%h expected=%h at cycle %0d", obs, e[16:1], cyc);
                end
            end
            prev_obs = obs;
            check("digits_live", 32'(digits), 32'(exp_digits(mval, blank_leading)));
            check("decimal_live", 32'(decimal), 32'd1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] m, input logic [1:0] s);
        step = s;
        {btn_clear, btn_down, btn_up} = m;
        tick(6);
        {btn_clear, btn_down, btn_up} = 3'b000;
        tick(D + 6);
    endtask

    task automatic check_value(input string name, input logic [15:0] exp_v);
        check(name, 32'({v3, v2, v1, v0}), 32'(exp_v));
    endtask

    task automatic check_mask(input string name, input logic [3:0] exp_bl1);
        blank_leading = 1'b1;
        #1;
        check({name, "_bl1"}, 32'(digits), 32'(exp_bl1));
        blank_leading = 1'b0;
        #1;
        check({name, "_bl0"}, 32'(digits), 32'hf);
        blank_leading = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        {btn_clear, btn_down, btn_up} = 3'b000;
        step = 2'd0;
        blank_leading = 1'b1;
        tick(2);
        rst = 1'b0;
        check_value("reset_v", 16'h0000);
        check("reset_digits", 32'(digits), 32'h1);
        check("reset_wrap", 32'(wrap), 32'd0);
        check("reset_decimal", 32'(decimal), 32'd1);

        // held 10 cycles: one increment, no repeat
        btn_up = 1'b1;
        tick(10);
        btn_up = 1'b0;
        tick(D + 6);
        check_value("held_once", 16'h0001);

        // glitchy press rejected, clean press accepted
        btn_up = 1'b1; tick(3);
        btn_up = 1'b0; tick(1);
        btn_up = 1'b1; tick(3);
        btn_up = 1'b0; tick(D + 6);
        check_value("glitch_reject", 16'h0001);
        press(3'b001, 2'd0);
        check_value("after_glitch", 16'h0002);

        // wrap both ways at the units digit
        press(3'b100, 2'd0);
        press(3'b010, 2'd0);
        check_value("wrap_down", 16'h9999);
        press(3'b001, 2'd0);
        check_value("wrap_up", 16'h0000);

        // 9500 + 1000 wraps to 0500
        press(3'b010, 2'd3);
        repeat (5) press(3'b001, 2'd2);
        check_value("reach_9500", 16'h9500);
        press(3'b001, 2'd3);
        check_value("wrap_thousands", 16'h0500);

        // 0095 + 10 carries into hundreds without wrap
        press(3'b100, 2'd0);
        repeat (9) press(3'b001, 2'd1);
        repeat (5) press(3'b001, 2'd0);
        press(3'b001, 2'd1);
        check_value("carry_0105", 16'h0105);
        check_mask("mask_0105", 4'b0111);

        // priority: up+down cancel, clear beats up
        press(3'b011, 2'd0);
        check_value("up_down_cancel", 16'h0105);
        press(3'b101, 2'd0);
        check_value("clear_beats_up", 16'h0000);
        check_mask("mask_0000", 4'b0001);

        repeat (7) press(3'b001, 2'd0);
        check_mask("mask_0007", 4'b0001);
        press(3'b100, 2'd0);
        repeat (3) press(3'b001, 2'd3);
        check_value("reach_3000", 16'h3000);
        check_mask("mask_3000", 4'b1111);

        // reset while down is mid-debounce; still held afterwards
        press(3'b100, 2'd0);
        step = 2'd0;
        btn_down = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(12);
        btn_down = 1'b0;
        tick(D + 6);
        check_value("reset_mid_press", 16'h9999);

        // randomized button activity
        for (int i = 0; i < 400; i++) begin
            btn_clear = ($urandom_range(0, 7) == 0);
            btn_down  = 1'($urandom_range(0, 1));
            btn_up    = 1'($urandom_range(0, 1));
            step      = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) blank_leading = ~blank_leading;
            tick($urandom_range(1, 7));
        end
        {btn_clear, btn_down, btn_up} = 3'b000;
        tick(20);

        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check_value("final_value", to_bcd(mval));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=finish at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
